window_kxk_stream: RTL and testbench

- Parametrised successor to the 3x3 streaming window generator. Builds KxK sliding windows over a raster-scanned, multi-channel pixel stream.
- Adds a valid/ready handshake on both sides, configurable stride, frame resync on start-of-frame (sof), and a last-window flag.
- Sits between the pixel source and the per-channel convolution/scale stages; feeds one KxK window per channel per output beat.

---
 rtl/window_kxk_stream.sv | 136 +++++++++++++
 tb/tb_window_kxk_stream.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_kxk_stream.sv
// Streaming KxK window generator over a raster-scanned multi-channel pixel stream,
// with valid/ready on both sides, configurable stride, sof resync and last-window flag.
module window_kxk_stream #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned IMG_WIDTH  = 5,
  parameter int unsigned IMG_HEIGHT = 5,
  parameter int unsigned K          = 3,
  parameter int unsigned CHANNELS   = 1,
  parameter int unsigned STRIDE     = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic                                 in_sof,
  input  logic [CHANNELS*DATA_WIDTH-1:0]       in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [CHANNELS*K*K*DATA_WIDTH-1:0]   out_window,
  output logic                                 out_last
);

  localparam int unsigned CW       = $clog2(IMG_WIDTH);
  localparam int unsigned RW       = $clog2(IMG_HEIGHT);
  localparam int unsigned NL       = K - 1;
  localparam int unsigned LAST_ROW = (K - 1) + ((IMG_HEIGHT - K) / STRIDE) * STRIDE;
  localparam int unsigned LAST_COL = (K - 1) + ((IMG_WIDTH - K) / STRIDE) * STRIDE;
  localparam int unsigned WIN_W    = CHANNELS * K * K * DATA_WIDTH;

  logic [DATA_WIDTH-1:0] r_lb       [CHANNELS][NL][IMG_WIDTH];
  logic [DATA_WIDTH-1:0] r_arr      [CHANNELS][K][K];
  logic [DATA_WIDTH-1:0] w_arr_next [CHANNELS][K][K];
  logic [CW-1:0]         r_col, w_col, w_col_next;
  logic [RW-1:0]         r_row, w_row, w_row_next;
  logic [31:0]           w_row32, w_col32;
  logic                  w_accept, w_emit, w_last;
  logic [WIN_W-1:0]      w_window;

  // Single output slot: accept whenever the slot is empty or being drained.
  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // sof forces the current pixel to (0,0) regardless of the counters.
  assign w_col   = in_sof ? '0 : r_col;
  assign w_row   = in_sof ? '0 : r_row;
  assign w_row32 = 32'(w_row);
  assign w_col32 = 32'(w_col);

  assign w_emit = (w_row32 >= K - 1) && (w_col32 >= K - 1) &&
                  (((w_row32 - (K - 1)) % STRIDE) == 32'd0) &&
                  (((w_col32 - (K - 1)) % STRIDE) == 32'd0);
  assign w_last = (w_row32 == LAST_ROW) && (w_col32 == LAST_COL);

  // Raster counters advance from the (possibly resynced) current position.
  always_comb begin
    w_col_next = w_col + CW'(1);
    w_row_next = w_row;
    if (w_col == CW'(IMG_WIDTH - 1)) begin
      w_col_next = '0;
      w_row_next = (w_row == RW'(IMG_HEIGHT - 1)) ? '0 : w_row + RW'(1);
    end
  end

  // Shift array after this accept: rows shift left, newest column from line buffers + pixel.
  always_comb begin
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned k = 0; k < K - 1; k++) begin
          w_arr_next[c][r][k] = r_arr[c][r][k+1];
        end
      end
      for (int unsigned r = 0; r < K - 1; r++) begin
        w_arr_next[c][r][K-1] = r_lb[c][K-2-r][w_col];
      end
      w_arr_next[c][K-1][K-1] = in_data[c*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    w_window = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      for (int unsigned r = 0; r < K; r++) begin
        for (int unsigned k = 0; k < K; k++) begin
          w_window[((c*K + r)*K + k)*DATA_WIDTH +: DATA_WIDTH] = w_arr_next[c][r][k];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col      <= '0;
      r_row      <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      out_window <= '0;
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        for (int unsigned r = 0; r < K; r++) begin
          for (int unsigned k = 0; k < K; k++) begin
            r_arr[c][r][k] <= '0;
          end
        end
        for (int unsigned l = 0; l < NL; l++) begin
          for (int unsigned x = 0; x < IMG_WIDTH; x++) begin
            r_lb[c][l][x] <= '0;
          end
        end
      end
    end else begin
      if (w_accept) begin
        r_col <= w_col_next;
        r_row <= w_row_next;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
          for (int unsigned r = 0; r < K; r++) begin
            for (int unsigned k = 0; k < K; k++) begin
              r_arr[c][r][k] <= w_arr_next[c][r][k];
            end
          end
          r_lb[c][0][w_col] <= in_data[c*DATA_WIDTH +: DATA_WIDTH];
          for (int unsigned l = 1; l < NL; l++) begin
            r_lb[c][l][w_col] <= r_lb[c][l-1][w_col];
          end
        end
      end
      if (w_accept && w_emit) begin
        out_valid  <= 1'b1;
        out_window <= w_window;
        out_last   <= w_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_kxk_stream.sv
// Bench for window_kxk_stream: three configurations checked every cycle against an
// image-coordinate model, plus literal window contents for the directed frames.
module tb_window_kxk_stream;

  localparam int unsigned WB = 400;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    in_valid, in_sof, out_ready;
  logic [2:0]    in_ready_x, out_valid_x, out_last_x;
  logic [15:0]   in_data_x [3];
  logic [71:0]   win_a, win_b;
  logic [399:0]  win_c;
  logic [WB-1:0] win_x [3];

  always #5 clk = ~clk;

  window_kxk_stream #(.DATA_WIDTH(8), .IMG_WIDTH(5), .IMG_HEIGHT(5), .K(3), .CHANNELS(1), .STRIDE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready_x[0]), .in_sof(in_sof[0]),
    .in_data(in_data_x[0][7:0]), .out_valid(out_valid_x[0]), .out_ready(out_ready[0]),
    .out_window(win_a), .out_last(out_last_x[0]));

  window_kxk_stream #(.DATA_WIDTH(8), .IMG_WIDTH(5), .IMG_HEIGHT(5), .K(3), .CHANNELS(1), .STRIDE(2)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready_x[1]), .in_sof(in_sof[1]),
    .in_data(in_data_x[1][7:0]), .out_valid(out_valid_x[1]), .out_ready(out_ready[1]),
    .out_window(win_b), .out_last(out_last_x[1]));

  window_kxk_stream #(.DATA_WIDTH(8), .IMG_WIDTH(5), .IMG_HEIGHT(5), .K(5), .CHANNELS(2), .STRIDE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready_x[2]), .in_sof(in_sof[2]),
    .in_data(in_data_x[2]), .out_valid(out_valid_x[2]), .out_ready(out_ready[2]),
    .out_window(win_c), .out_last(out_last_x[2]));

  assign win_x[0] = WB'(win_a);
  assign win_x[1] = WB'(win_b);
  assign win_x[2] = win_c;

  int pk  [3] = '{3, 3, 5};
  int ps  [3] = '{1, 2, 1};
  int pch [3] = '{1, 1, 2};

  int            m_row [3];
  int            m_col [3];
  bit            exp_valid [3];
  bit            exp_last  [3];
  logic [WB-1:0] exp_win   [3];
  logic [7:0]    img [3][2][5][5];

  int            hs [3];
  logic [WB-1:0] wlog [3][64];
  bit            llog [3][64];

  logic [15:0]   s_d   [64];
  bit            s_sof [64];
  int            s_n;

  int n_vec = 0;
  int n_err = 0;

  int lit_first [9] = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
  int lit_last  [9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
  int lit_cen   [4] = '{6, 8, 16, 18};
  logic [WB-1:0] lit_first_vec;

  task automatic chk1(input string nm, input bit got, input bit exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", nm, got, exp);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chki(input string nm, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [WB-1:0] got, input logic [WB-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [7:0] elem(input logic [WB-1:0] w, input int kk, input int c,
                                      input int r, input int k);
    return w[((c*kk + r)*kk + k)*8 +: 8];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_row[i] = 0; m_col[i] = 0; exp_valid[i] = 1'b0; exp_last[i] = 1'b0; exp_win[i] = '0;
    end
  endtask

  // Image-coordinate model: a window is just the KxK patch of the frame ending at the pixel.
  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      bit acc, emit;
      int r, c, kk, s;
      logic [WB-1:0] ev;
      kk = pk[i]; s = ps[i]; emit = 1'b0;
      acc = in_valid[i] && (!exp_valid[i] || out_ready[i]);
      if (acc) begin
        r = in_sof[i] ? 0 : m_row[i];
        c = in_sof[i] ? 0 : m_col[i];
        img[i][0][r][c] = in_data_x[i][7:0];
        img[i][1][r][c] = in_data_x[i][15:8];
        emit = (r >= kk-1) && (c >= kk-1) && ((r-kk+1) % s == 0) && ((c-kk+1) % s == 0);
        if (emit) begin
          ev = '0;
          for (int ch = 0; ch < pch[i]; ch++)
            for (int a = 0; a < kk; a++)
              for (int b = 0; b < kk; b++)
                ev[((ch*kk + a)*kk + b)*8 +: 8] = img[i][ch][r-kk+1+a][c-kk+1+b];
          exp_win[i]  = ev;
          exp_last[i] = (r == kk-1 + ((5-kk)/s)*s) && (c == kk-1 + ((5-kk)/s)*s);
        end
        c++;
        if (c == 5) begin
          c = 0; r++;
          if (r == 5) r = 0;
        end
        m_row[i] = r; m_col[i] = c;
      end
      if (emit) exp_valid[i] = 1'b1;
      else if (out_ready[i]) exp_valid[i] = 1'b0;
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 3; i++) begin
      chk1($sformatf("inst%0d out_valid", i), out_valid_x[i], exp_valid[i]);
      chk1($sformatf("inst%0d in_ready", i), in_ready_x[i], !exp_valid[i] || out_ready[i]);
      if (exp_valid[i]) begin
        chkw($sformatf("inst%0d out_window", i), win_x[i], exp_win[i]);
        chk1($sformatf("inst%0d out_last", i), out_last_x[i], exp_last[i]);
      end
    end
  endtask

  task automatic hs_sample();
    for (int i = 0; i < 3; i++) begin
      if (rst_n && out_valid_x[i] && out_ready[i] && hs[i] < 64) begin
        wlog[i][hs[i]] = win_x[i];
        llog[i][hs[i]] = out_last_x[i];
        hs[i]++;
      end
    end
  endtask

  // One clock: starts and ends at a falling edge with inputs already driven.
  task automatic cycle(input int inst, output bit acc);
    #1;
    acc = in_valid[inst] && in_ready_x[inst];
    #3;
    hs_sample();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    if (rst_n) compare();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int t = 0; t < n; t++) cycle(0, a);
  endtask

  task automatic load_frame(input int inst);
    s_n = 25;
    for (int p = 0; p < 25; p++) begin
      s_d[p]   = (inst == 2) ? {8'(-p), 8'(p)} : 16'(p);
      s_sof[p] = 1'b0;
    end
  endtask

  task automatic send(input int inst, input bit bp);
    int idx, budget;
    bit acc, bp_done;
    idx = 0; budget = 300; bp_done = 1'b0;
    while (idx < s_n && budget > 0) begin
      in_valid[inst]  = 1'b1;
      in_data_x[inst] = s_d[idx];
      in_sof[inst]    = s_sof[idx];
      if (bp && !bp_done && out_valid_x[0]) begin
        out_ready[0] = 1'b0;
        for (int t = 0; t < 10; t++) begin
          cycle(inst, acc);
          chk1("stall in_ready", in_ready_x[0], 1'b0);
          chk1("stall out_valid", out_valid_x[0], 1'b1);
          chkw("stall window", win_x[0], lit_first_vec);
        end
        out_ready[0] = 1'b1;
        bp_done = 1'b1;
      end
      cycle(inst, acc);
      if (acc) idx++;
      budget--;
    end
    in_valid[inst] = 1'b0;
    in_sof[inst]   = 1'b0;
    chki($sformatf("inst%0d beats accepted", inst), idx, s_n);
  endtask

  task automatic check_frame_a(input int base, input string tag);
    int nl;
    chki({tag, " window count"}, hs[0] - base, 9);
    for (int j = 0; j < 9; j++) begin
      chk8($sformatf("%s first[%0d]", tag, j), elem(wlog[0][base], 3, 0, j/3, j%3), 8'(lit_first[j]));
      chk8($sformatf("%s last[%0d]", tag, j), elem(wlog[0][base+8], 3, 0, j/3, j%3), 8'(lit_last[j]));
    end
    nl = 0;
    for (int j = 0; j < 9; j++) nl += int'(llog[0][base+j]);
    chki({tag, " last count"}, nl, 1);
    chk1({tag, " last on 9th"}, llog[0][base+8], 1'b1);
  endtask

  initial begin
    int base;
    lit_first_vec = '0;
    for (int j = 0; j < 9; j++) lit_first_vec[j*8 +: 8] = 8'(lit_first[j]);
    for (int i = 0; i < 3; i++) begin
      hs[i] = 0; in_data_x[i] = '0;
    end
    rst_n = 1'b0; in_valid = '0; in_sof = '0; out_ready = 3'b111;
    model_reset();
    @(negedge clk);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 3; i++) begin
      chk1($sformatf("reset inst%0d out_valid", i), out_valid_x[i], 1'b0);
      chk1($sformatf("reset inst%0d in_ready", i), in_ready_x[i], 1'b1);
      chk1($sformatf("reset inst%0d out_last", i), out_last_x[i], 1'b0);
      chkw($sformatf("reset inst%0d out_window", i), win_x[i], '0);
    end

    // Plain frame, full throughput
    base = hs[0]; load_frame(0); send(0, 1'b0); idle(3);
    check_frame_a(base, "plain");

    // Backpressure after the first window
    base = hs[0]; load_frame(0); send(0, 1'b1); idle(3);
    check_frame_a(base, "backpressure");

    // Partial frame of distinct values, then sof restarts a clean frame
    base = hs[0];
    s_n = 32;
    for (int p = 0; p < 7; p++) begin
      s_d[p] = 16'(100 + p); s_sof[p] = 1'b0;
    end
    for (int p = 0; p < 25; p++) begin
      s_d[7+p] = 16'(p); s_sof[7+p] = (p == 0);
    end
    send(0, 1'b0); idle(3);
    check_frame_a(base, "sof");

    // Reset with a window pending, then a fresh frame
    s_n = 13;
    for (int p = 0; p < 13; p++) begin
      s_d[p] = 16'(50 + p); s_sof[p] = 1'b0;
    end
    send(0, 1'b0);
    chk1("pre-reset out_valid", out_valid_x[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("async reset out_valid", out_valid_x[0], 1'b0);
    chk1("async reset out_last", out_last_x[0], 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    base = hs[0]; load_frame(0); send(0, 1'b0); idle(3);
    check_frame_a(base, "after reset");

    // Stride 2
    base = hs[1]; load_frame(1); send(1, 1'b0); idle(3);
    chki("stride2 window count", hs[1] - base, 4);
    for (int j = 0; j < 4; j++)
      chk8($sformatf("stride2 centre[%0d]", j), elem(wlog[1][base+j], 3, 0, 1, 1), 8'(lit_cen[j]));
    chk8("stride2 first top-left", elem(wlog[1][base], 3, 0, 0, 0), 8'd0);
    chk8("stride2 last bottom-right", elem(wlog[1][base+3], 3, 0, 2, 2), 8'd24);
    chk1("stride2 last flag", llog[1][base+3], 1'b1);
    chk1("stride2 not last", llog[1][base+2], 1'b0);

    // Two channels, K=5: one window, ch1 negated
    base = hs[2]; load_frame(2); send(2, 1'b0); idle(3);
    chki("k5 window count", hs[2] - base, 1);
    chk1("k5 last flag", llog[2][base], 1'b1);
    for (int r = 0; r < 5; r++)
      for (int k = 0; k < 5; k++) begin
        chk8($sformatf("k5 ch0[%0d][%0d]", r, k), elem(wlog[2][base], 5, 0, r, k), 8'(r*5 + k));
        chk8($sformatf("k5 ch1[%0d][%0d]", r, k), elem(wlog[2][base], 5, 1, r, k), 8'(-(r*5 + k)));
      end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
